mem_bridge8: RTL and testbench

//  Bridge between the core's 32-bit word bus and an 8-bit synchronous RAM (BRAM or ext. SRAM).

---
 rtl/mem_bridge8_pkg.sv | 26 ++
 rtl/mem_bridge8.sv | 160 ++++++++++++++++
 tb/tb_mem_bridge8.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bridge8_pkg.sv
// mem_bridge8_pkg
//   Shared definitions for the 32-bit word to 8-bit RAM bridge.
//   Contents:
//     ST_IDLE/ST_XFER/ST_DONE  bridge FSM state encodings
//     BYTES_PER_WORD           byte cycles per core word
//     byte_lane()              extract little-endian byte lane k of a word
package mem_bridge8_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] lane;
        case (k)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/mem_bridge8.sv
// mem_bridge8
//   Bridges the core's 32-bit word bus to an 8-bit synchronous RAM. Each core
//   access becomes four little-endian byte slots of 1+WAIT cycles; the core is
//   stalled through 'ce' until the word is complete.
//
//   State table
//     state    | meaning
//     ST_IDLE  | waiting for core_rd/core_w; ce follows ~req
//     ST_XFER  | running byte slots 0..3 on the RAM side, core stalled
//     ST_DONE  | last read byte arrives, ce=1 for one cycle
//
//   Ports
//     clock    in   1       system clock, posedge
//     rst_n    in   1       asynchronous active-low reset
//     core_a   in   32      core byte address (bits [1:0] ignored)
//     core_o   in   32      core write data
//     core_w   in   1       write request (wins over core_rd)
//     core_rd  in   1       read request
//     core_be  in   4       write byte enables, bit k = lane k
//     core_i   out  32      assembled read word
//     ce       out  1       core clock enable, 0 = stall
//     mem_a    out  ADDR_W  RAM byte address
//     mem_i    in   8       RAM read data, one cycle after mem_a
//     mem_o    out  8       RAM write data
//     mem_w    out  1       RAM write strobe
module mem_bridge8
    import mem_bridge8_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int WAIT   = 0
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [31:0]       core_a,
    input  logic [31:0]       core_o,
    input  logic              core_w,
    input  logic              core_rd,
    input  logic [3:0]        core_be,
    output logic [31:0]       core_i,
    output logic              ce,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [7:0]        mem_i,
    output logic [7:0]        mem_o,
    output logic              mem_w
);

    localparam int CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT);

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       data_q;
    logic [3:0]        be_q;
    logic              wr_q;
    logic [1:0]        k_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [23:0]       rbuf_q;
    logic [31:0]       word_q;

    logic              req;
    logic [ADDR_W-1:0] base_in;
    logic [1:0]        k_next;

    assign req     = core_rd | core_w;
    assign base_in = {core_a[ADDR_W-1:2], 2'b00};
    assign k_next  = k_q + 2'd1;

    generate
        if (ADDR_W < 32) begin : g_unused_hi
            logic unused_core_a;
            assign unused_core_a = ^{core_a[31:ADDR_W], core_a[1:0]};
        end else begin : g_unused_lo
            logic unused_core_a;
            assign unused_core_a = ^core_a[1:0];
        end
    endgenerate

    always_comb begin
        ce = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: ce = ~req;
                ST_DONE: ce = 1'b1;
                default: ce = 1'b0;
            endcase
        end
    end

    // With a synchronous RAM, byte 3 only appears on mem_i during DONE, the very
    // cycle the core samples with ce=1, so it is forwarded straight through.
    // word_q takes the same value at the end of DONE and holds it afterwards.
    assign core_i = (state == ST_DONE && !wr_q) ? {mem_i, rbuf_q} : word_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            base_q <= '0;
            data_q <= '0;
            be_q   <= '0;
            wr_q   <= 1'b0;
            k_q    <= '0;
            cnt_q  <= '0;
            rbuf_q <= '0;
            word_q <= '0;
            mem_a  <= '0;
            mem_o  <= '0;
            mem_w  <= 1'b0;
        end else begin
            mem_w <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        base_q <= base_in;
                        data_q <= core_o;
                        be_q   <= core_be;
                        wr_q   <= core_w;
                        k_q    <= '0;
                        cnt_q  <= '0;
                        mem_a  <= base_in;
                        mem_o  <= core_o[7:0];
                        mem_w  <= core_w & core_be[0];
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Previous slot's byte is on mem_i during the first cycle of this slot.
                    if (cnt_q == '0 && !wr_q) begin
                        case (k_q)
                            2'd1:    rbuf_q[7:0]   <= mem_i;
                            2'd2:    rbuf_q[15:8]  <= mem_i;
                            2'd3:    rbuf_q[23:16] <= mem_i;
                            default: ;
                        endcase
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (k_q == 2'd3) begin
                            state <= ST_DONE;
                        end else begin
                            k_q   <= k_next;
                            mem_a <= base_q + {{(ADDR_W-2){1'b0}}, k_next};
                            mem_o <= byte_lane(data_q, k_next);
                            mem_w <= wr_q & be_q[k_next];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!wr_q) begin
                        word_q <= {mem_i, rbuf_q};
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge8.sv
module tb_mem_bridge8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n;
    logic [31:0] core_a, core_o;
    logic [3:0]  core_be;
    logic        rd_req, wr_req, sel;
    logic        rd0, w0, rd2, w2;

    logic [31:0] core_i0, core_i2;
    logic        ce0, ce2;
    logic [19:0] mem_a0, mem_a2;
    logic [7:0]  mem_i0 = 8'h00, mem_i2 = 8'h00;
    logic [7:0]  mem_o0, mem_o2;
    logic        mem_w0, mem_w2;

    assign rd0 = rd_req & ~sel;
    assign w0  = wr_req & ~sel;
    assign rd2 = rd_req & sel;
    assign w2  = wr_req & sel;

    mem_bridge8 #(.ADDR_W(20), .WAIT(0)) dut0 (
        .clock(clock), .rst_n(rst_n), .core_a(core_a), .core_o(core_o),
        .core_w(w0), .core_rd(rd0), .core_be(core_be), .core_i(core_i0),
        .ce(ce0), .mem_a(mem_a0), .mem_i(mem_i0), .mem_o(mem_o0), .mem_w(mem_w0));

    mem_bridge8 #(.ADDR_W(20), .WAIT(2)) dut2 (
        .clock(clock), .rst_n(rst_n), .core_a(core_a), .core_o(core_o),
        .core_w(w2), .core_rd(rd2), .core_be(core_be), .core_i(core_i2),
        .ce(ce2), .mem_a(mem_a2), .mem_i(mem_i2), .mem_o(mem_o2), .mem_w(mem_w2));

    logic        s_ce, s_mem_w;
    logic [19:0] s_mem_a;
    logic [7:0]  s_mem_o;
    logic [31:0] s_core_i;
    assign s_ce     = sel ? ce2 : ce0;
    assign s_mem_w  = sel ? mem_w2 : mem_w0;
    assign s_mem_a  = sel ? mem_a2 : mem_a0;
    assign s_mem_o  = sel ? mem_o2 : mem_o0;
    assign s_core_i = sel ? core_i2 : core_i0;

    // RAM models (sync read, read-before-write) and transaction-level golden memories
    logic [7:0] ram0  [logic [19:0]];
    logic [7:0] ram2  [logic [19:0]];
    logic [7:0] gold0 [logic [19:0]];
    logic [7:0] gold2 [logic [19:0]];

    function automatic logic [7:0] init_byte(input logic [19:0] a);
        return a[7:0] ^ a[19:12] ^ 8'hA5;
    endfunction

    always @(posedge clock) begin
        mem_i0 <= ram0.exists(mem_a0) ? ram0[mem_a0] : init_byte(mem_a0);
        mem_i2 <= ram2.exists(mem_a2) ? ram2[mem_a2] : init_byte(mem_a2);
        if (mem_w0) ram0[mem_a0] = mem_o0;
        if (mem_w2) ram2[mem_a2] = mem_o2;
    end

    function automatic logic [7:0] gold_rd(input logic s, input logic [19:0] a);
        if (s) return gold2.exists(a) ? gold2[a] : init_byte(a);
        return gold0.exists(a) ? gold0[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ram_rd(input logic s, input logic [19:0] a);
        if (s) return ram2.exists(a) ? ram2[a] : init_byte(a);
        return ram0.exists(a) ? ram0[a] : init_byte(a);
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    int          obs_ce_low, obs_addr_n, obs_wr_n;
    logic [63:0] obs_addr_sig, obs_wr_sig;
    logic [31:0] obs_word, obs_word_after;

    int          e_ce_low, e_addr_n, e_wr_n;
    logic [63:0] e_addr_sig, e_wr_sig;
    logic [31:0] e_word;
    logic [31:0] last_rd [2];

    // Presents one request starting in the current cycle and records what the
    // RAM side and the core side saw until ce returns. Returns #1 into the
    // cycle after ce=1, so a following call is back-to-back.
    task automatic run_txn(input logic s, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        bit done;
        done = 0;
        sel = s; core_a = a; core_o = d; core_be = be;
        wr_req = w; rd_req = ~w;
        obs_ce_low = 0; obs_addr_n = 0; obs_wr_n = 0;
        obs_addr_sig = 64'd0; obs_wr_sig = 64'd0; obs_word = 32'd0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (s_ce) begin
                obs_word = s_core_i;
                done = 1;
            end else begin
                obs_ce_low++;
                if (i > 0) begin
                    obs_addr_sig = obs_addr_sig * 64'd1000003 + 64'(s_mem_a);
                    obs_addr_n++;
                end
            end
            if (s_mem_w) begin
                obs_wr_sig = obs_wr_sig * 64'd1000003 + 64'({s_mem_a, s_mem_o});
                obs_wr_n++;
            end
            @(posedge clock); #1;
            rd_req = 0; wr_req = 0;
        end
        if (!done) obs_ce_low = -1;
        obs_word_after = s_core_i;
    endtask

    // Expected behaviour of one access from the bridge's rules: 4 byte slots of
    // 1+WAIT cycles on consecutive 20-bit addresses, lane-enabled writes on the
    // first cycle of each slot, little-endian assembly for reads.
    task automatic model_txn(input logic s, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        logic [19:0] base, ak;
        int wt;
        base = {a[19:2], 2'b00};
        wt = s ? 2 : 0;
        e_ce_low = 1 + 4 * (1 + wt);
        e_addr_sig = 64'd0; e_addr_n = 0; e_wr_sig = 64'd0; e_wr_n = 0;
        e_word = 32'd0;
        for (int k = 0; k < 4; k++) begin
            ak = base + 20'(k);
            for (int r = 0; r <= wt; r++) begin
                e_addr_sig = e_addr_sig * 64'd1000003 + 64'(ak);
                e_addr_n++;
            end
            if (w && be[k]) begin
                e_wr_sig = e_wr_sig * 64'd1000003 + 64'({ak, d[8*k +: 8]});
                e_wr_n++;
                if (s) gold2[ak] = d[8*k +: 8];
                else   gold0[ak] = d[8*k +: 8];
            end
            if (!w) e_word[8*k +: 8] = gold_rd(s, ak);
        end
        if (w) e_word = last_rd[s];
        else   last_rd[s] = e_word;
    endtask

    task automatic test_reset();
        rst_n = 0; sel = 0; rd_req = 1; wr_req = 0;
        core_a = 32'h100; core_o = 32'h0; core_be = 4'h0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        #22;
        n_cmp++;
        if (ce0 !== 1'b0 || ce2 !== 1'b0) begin
            n_bad++; $display("FAIL reset_ce got %b/%b want 0/0", ce0, ce2);
        end
        n_cmp++;
        if (mem_a0 !== 20'd0 || mem_a2 !== 20'd0 || mem_w0 !== 1'b0 || mem_w2 !== 1'b0) begin
            n_bad++; $display("FAIL reset_mem got a=%h/%h w=%b/%b want 0", mem_a0, mem_a2, mem_w0, mem_w2);
        end
        n_cmp++;
        if (core_i0 !== 32'd0 || core_i2 !== 32'd0 || mem_o0 !== 8'd0) begin
            n_bad++; $display("FAIL reset_core_i got %h/%h want 0", core_i0, core_i2);
        end
        rd_req = 0;
        @(negedge clock); rst_n = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_read_basic();
        ram0[20'h100] = 8'h78; ram0[20'h101] = 8'h56; ram0[20'h102] = 8'h34; ram0[20'h103] = 8'h12;
        gold0[20'h100] = 8'h78; gold0[20'h101] = 8'h56; gold0[20'h102] = 8'h34; gold0[20'h103] = 8'h12;
        model_txn(0, 0, 32'h102, 32'h0, 4'h0);
        run_txn(0, 0, 32'h102, 32'h0, 4'h0);
        n_cmp++;
        if (obs_ce_low !== 5) begin
            n_bad++; $display("FAIL rd_ce_low got %0d want 5", obs_ce_low);
        end
        n_cmp++;
        if (obs_addr_sig !== e_addr_sig || obs_addr_n !== e_addr_n) begin
            n_bad++; $display("FAIL rd_addr_seq got %h(%0d) want %h(%0d)", obs_addr_sig, obs_addr_n, e_addr_sig, e_addr_n);
        end
        n_cmp++;
        if (obs_word !== 32'h12345678) begin
            n_bad++; $display("FAIL rd_word got %h want 12345678", obs_word);
        end
        n_cmp++;
        if (obs_word_after !== 32'h12345678 || obs_wr_n !== 0) begin
            n_bad++; $display("FAIL rd_hold got %h wr=%0d want 12345678 wr=0", obs_word_after, obs_wr_n);
        end
    endtask

    task automatic test_write_basic();
        logic [31:0] want;
        model_txn(0, 1, 32'h200, 32'hAABBCCDD, 4'b0101);
        run_txn(0, 1, 32'h200, 32'hAABBCCDD, 4'b0101);
        n_cmp++;
        if (obs_wr_sig !== e_wr_sig || obs_wr_n !== 2) begin
            n_bad++; $display("FAIL wr_pulses got %h(%0d) want %h(2)", obs_wr_sig, obs_wr_n, e_wr_sig);
        end
        n_cmp++;
        if (obs_ce_low !== 5 || obs_addr_sig !== e_addr_sig) begin
            n_bad++; $display("FAIL wr_timing got ce_low=%0d sig=%h want 5 sig=%h", obs_ce_low, obs_addr_sig, e_addr_sig);
        end
        n_cmp++;
        if (obs_word !== 32'h12345678 || obs_word_after !== 32'h12345678) begin
            n_bad++; $display("FAIL wr_keeps_core_i got %h/%h want 12345678", obs_word, obs_word_after);
        end
        want = {init_byte(20'h203), 8'hBB, init_byte(20'h201), 8'hDD};
        model_txn(0, 0, 32'h200, 32'h0, 4'h0);
        run_txn(0, 0, 32'h200, 32'h0, 4'h0);
        n_cmp++;
        if (obs_word !== want || obs_word !== e_word) begin
            n_bad++; $display("FAIL wr_readback got %h want %h", obs_word, want);
        end
    endtask

    task automatic test_back_to_back();
        int ce_a, wr_a;
        logic [31:0] word_a, ew_a;
        model_txn(0, 0, 32'h100, 32'h0, 4'h0);
        ew_a = e_word;
        run_txn(0, 0, 32'h100, 32'h0, 4'h0);
        ce_a = obs_ce_low; wr_a = obs_wr_n; word_a = obs_word;
        model_txn(0, 1, 32'h104, 32'h11223344, 4'b1001);
        run_txn(0, 1, 32'h104, 32'h11223344, 4'b1001);
        n_cmp++;
        if (ce_a !== 5 || obs_ce_low !== 5) begin
            n_bad++; $display("FAIL b2b_ce_pattern got %0d,%0d want 5,5", ce_a, obs_ce_low);
        end
        n_cmp++;
        if (word_a !== ew_a || wr_a !== 0) begin
            n_bad++; $display("FAIL b2b_read got %h wr=%0d want %h wr=0", word_a, wr_a, ew_a);
        end
        n_cmp++;
        if (obs_wr_sig !== e_wr_sig || obs_wr_n !== e_wr_n || obs_addr_sig !== e_addr_sig) begin
            n_bad++; $display("FAIL b2b_write got %h(%0d) want %h(%0d)", obs_wr_sig, obs_wr_n, e_wr_sig, e_wr_n);
        end
    endtask

    task automatic test_wait2();
        logic [31:0] a;
        a = {12'h0, 10'h0, 8'($urandom_range(0, 255)), 2'b00} | 32'h400;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] v;
            v = 8'($urandom);
            ram2[a[19:0] + 20'(k)] = v;
            gold2[a[19:0] + 20'(k)] = v;
        end
        model_txn(1, 0, a, 32'h0, 4'h0);
        run_txn(1, 0, a, 32'h0, 4'h0);
        n_cmp++;
        if (obs_ce_low !== 13) begin
            n_bad++; $display("FAIL w2_ce_low got %0d want 13", obs_ce_low);
        end
        n_cmp++;
        if (obs_addr_sig !== e_addr_sig || obs_addr_n !== 12) begin
            n_bad++; $display("FAIL w2_addr_seq got %h(%0d) want %h(12)", obs_addr_sig, obs_addr_n, e_addr_sig);
        end
        n_cmp++;
        if (obs_word !== e_word || obs_word_after !== e_word) begin
            n_bad++; $display("FAIL w2_word got %h/%h want %h", obs_word, obs_word_after, e_word);
        end
    endtask

    task automatic test_idle_wrap();
        logic [19:0] hold0, hold2;
        int bad;
        sel = 0; rd_req = 0; wr_req = 0;
        hold0 = mem_a0; hold2 = mem_a2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            bad = 0;
            if (ce0 !== 1'b1 || ce2 !== 1'b1 || mem_w0 !== 1'b0 || mem_w2 !== 1'b0) bad = 1;
            if (mem_a0 !== hold0 || mem_a2 !== hold2) bad = 1;
            n_cmp++;
            if (bad) begin
                n_bad++; $display("FAIL idle cyc%0d got ce=%b%b w=%b%b a=%h/%h want 11 00 %h/%h", i, ce0, ce2, mem_w0, mem_w2, mem_a0, mem_a2, hold0, hold2);
            end
        end
        @(posedge clock); #1;
        model_txn(0, 0, 32'hABCFFFFE, 32'h0, 4'h0);
        run_txn(0, 0, 32'hABCFFFFE, 32'h0, 4'h0);
        n_cmp++;
        if (obs_addr_sig !== e_addr_sig || obs_word !== e_word || obs_ce_low !== 5) begin
            n_bad++; $display("FAIL wrap_read got %h/%h want %h/%h", obs_addr_sig, obs_word, e_addr_sig, e_word);
        end
        model_txn(1, 1, 32'h000FFFFF, 32'hCAFEF00D, 4'hF);
        run_txn(1, 1, 32'h000FFFFF, 32'hCAFEF00D, 4'hF);
        n_cmp++;
        if (obs_wr_sig !== e_wr_sig || obs_wr_n !== 4 || obs_ce_low !== 13) begin
            n_bad++; $display("FAIL wrap_write got %h(%0d) want %h(4)", obs_wr_sig, obs_wr_n, e_wr_sig);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] old2, old3;
        old2 = gold_rd(0, 20'h302);
        old3 = gold_rd(0, 20'h303);
        sel = 0; core_a = 32'h300; core_o = 32'h44332211; core_be = 4'hF;
        wr_req = 1; rd_req = 0;
        @(posedge clock); #1; wr_req = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        // slot 2 is now on the RAM side with its strobe up
        rst_n = 0;
        #1;
        n_cmp++;
        if (mem_w0 !== 1'b0 || ce0 !== 1'b0 || mem_a0 !== 20'd0 || core_i0 !== 32'd0) begin
            n_bad++; $display("FAIL rst_mid_outputs got w=%b ce=%b a=%h ci=%h want 0", mem_w0, ce0, mem_a0, core_i0);
        end
        gold0[20'h300] = 8'h11; gold0[20'h301] = 8'h22;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        repeat (2) @(posedge clock);
        n_cmp++;
        if (ram_rd(0, 20'h300) !== 8'h11 || ram_rd(0, 20'h301) !== 8'h22) begin
            n_bad++; $display("FAIL rst_mid_early_bytes got %h %h want 11 22", ram_rd(0, 20'h300), ram_rd(0, 20'h301));
        end
        n_cmp++;
        if (ram_rd(0, 20'h302) !== old2 || ram_rd(0, 20'h303) !== old3) begin
            n_bad++; $display("FAIL rst_mid_late_bytes got %h %h want %h %h", ram_rd(0, 20'h302), ram_rd(0, 20'h303), old2, old3);
        end
        @(negedge clock); rst_n = 1;
        @(negedge clock);
        n_cmp++;
        if (ce0 !== 1'b1 || mem_a0 !== 20'd0 || mem_w0 !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_release got ce=%b a=%h w=%b want 1 0 0", ce0, mem_a0, mem_w0);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_random();
        logic        s, w;
        logic [31:0] a, d;
        logic [3:0]  be;
        int          gap;
        for (int n = 0; n < 40; n++) begin
            s  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFF0_03FF;
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            model_txn(s, w, a, d, be);
            run_txn(s, w, a, d, be);
            n_cmp++;
            if (obs_ce_low !== e_ce_low || obs_addr_sig !== e_addr_sig || obs_addr_n !== e_addr_n) begin
                n_bad++; $display("FAIL rnd%0d_timing got ce_low=%0d sig=%h want %0d sig=%h", n, obs_ce_low, obs_addr_sig, e_ce_low, e_addr_sig);
            end
            n_cmp++;
            if (obs_wr_sig !== e_wr_sig || obs_wr_n !== e_wr_n) begin
                n_bad++; $display("FAIL rnd%0d_writes got %h(%0d) want %h(%0d)", n, obs_wr_sig, obs_wr_n, e_wr_sig, e_wr_n);
            end
            n_cmp++;
            if (obs_word !== e_word || obs_word_after !== e_word) begin
                n_bad++; $display("FAIL rnd%0d_word got %h/%h want %h", n, obs_word, obs_word_after, e_word);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_back_to_back();
        test_wait2();
        test_idle_wrap();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
